// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory request/response bundle.
// master = MEM stage (drives requests), slave = dmem_responder.
interface dmem_if;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        resp_valid;
  logic        align_err;

  modport master (
    output MemRead, MemWrite, address, write_data,
    input  read_data, mem_stall, resp_valid, align_err
  );

  modport slave (
    input  MemRead, MemWrite, address, write_data,
    output read_data, mem_stall, resp_valid, align_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: services MEM-stage loads/stores against a word-organised,
// byte-lane-writable array. Stores complete in the request cycle; loads stall
// the pipeline for READ_LAT BUSY cycles plus the issue cycle, then present a
// registered word for one RESP cycle.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misalignment detection,
// align_err pulse, suppression of misaligned stores).
module dmem_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [AW-1:0]  idx;
  logic [31:0]    read_data_q;
  logic           resp_valid_q;
  logic           align_err_q;

  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  widx;
  logic           is_store;
  logic           is_load;
  logic           misalign;
  logic [3:0]     lane_en;
  logic [31:0]    lane_data;

  // Upper address bits above the array index are ignored, giving modulo wrap.
  assign widx     = bus.address[AW+1:2];
  assign is_store = (bus.MemWrite != 2'b00);
  // A store wins over a simultaneous read; the read is dropped.
  assign is_load  = bus.MemRead && !is_store;

`ifdef DMEM_ALIGN_CHECK_EN
  // Flag halfword accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    misalign = 1'b0;
    case (bus.MemWrite)
      2'b10:   misalign = bus.address[0];
      2'b11:   misalign = (bus.address[1:0] != 2'b00);
      default: misalign = bus.MemRead && (bus.address[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Steer right-justified store data onto the byte lanes it targets.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = bus.write_data;
    case (bus.MemWrite)
      2'b01: begin
        lane_en   = 4'b0001 << bus.address[1:0];
        lane_data = {4{bus.write_data[7:0]}};
      end
      2'b10: begin
        lane_en   = bus.address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.write_data[15:0]}};
      end
      2'b11:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    if (misalign) lane_en = 4'b0000;
  end

  // Pipeline hold: issue cycle and every BUSY cycle; never while in reset.
  assign bus.mem_stall = rst_n && (((state == IDLE) && is_load) || (state == BUSY));

  assign bus.read_data  = read_data_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.align_err  = align_err_q;

  // Byte-lane store into the array; only accepted in IDLE and out of reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are undefined until written.
    if (rst_n && (state == IDLE)) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[widx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // Request FSM with registered load data, response pulse and alignment pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      idx          <= '0;
      read_data_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          align_err_q <= misalign && (is_store || bus.MemRead);
          if (is_load) begin
            idx   <= widx;
            cnt   <= 4'(READ_LAT - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            read_data_q  <= mem[idx];
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Inputs still carry the completing request; ignore them.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the MEM-stage data-memory interface. It accepts the load/store requests the MEM stage drives (MemRead, 2-bit MemWrite, address, write data) and services them against a word-organised, byte-lane-writable storage array. Stores complete in one cycle. Loads take a fixed, parameterised latency, during which the responder holds the pipeline with a stall. Load data is a registered 32-bit word; sign/zero extension happens downstream in WB.

## Interface
Parameters:
- DEPTH, 1024: storage size in 32-bit words; power of two.
- READ_LAT, 2: load access cycles spent in BUSY; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- MemRead  input  1  load request.
- MemWrite  input  2  store request and width: 00 none, 01 byte, 10 halfword, 11 word.
- address  input  32  byte address; word index = address[log2(DEPTH)+1:2], upper bits ignored (modulo wrap).
- write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- read_data  output  32  registered load word.
- mem_stall  output  1  pipeline hold; combinational from state and inputs.
- resp_valid  output  1  one-cycle pulse when read_data carries a new load result.
- align_err  output  1  one-cycle registered pulse on a misaligned access.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE, MemWrite != 00:
  - Store accepted this cycle; no stall.
  - Byte: lane address[1:0] <= write_data[7:0].
  - Half: lanes {address[1],0} and {address[1],1} <= write_data[15:0].
  - Word: all lanes.
  - Other lanes unchanged. Stay IDLE.
- IDLE, MemRead with MemWrite == 00:
  - Latch word index, load cnt = READ_LAT-1, go BUSY.
  - mem_stall = 1 in this cycle.
- Simultaneous MemRead and MemWrite != 00: the store wins and the read is dropped. This combination is illegal upstream.
- BUSY:
  - mem_stall = 1; cnt decrements each cycle.
  - When cnt == 0: read_data <= mem[latched index], resp_valid <= 1, go RESP.
- RESP:
  - mem_stall = 0 and resp_valid = 1.
  - Inputs are ignored, because they are still the completing request.
  - Next state IDLE unconditionally.
- read_data holds its last value until the next load completes.
- Storage is not cleared by reset; its contents are undefined until written.

## Timing
- Reset values: state IDLE, cnt 0, read_data 0x0000_0000, resp_valid 0, align_err 0. While rst_n = 0, mem_stall = 0 and no request is accepted.
- Store latency: array updated at the edge ending the request cycle. A load issued in the next cycle returns the new data.
- Load stalls: mem_stall is high for READ_LAT+1 consecutive cycles (the IDLE issue cycle plus READ_LAT BUSY cycles), then low for the RESP cycle, during which the pipeline advances.
- Back-to-back loads: the next load can issue in the IDLE cycle immediately after RESP. Throughput is one load per READ_LAT+2 cycles.
- Reset asserted during BUSY or RESP aborts the load: state returns to IDLE, resp_valid stays 0, and read_data is cleared to 0.
- Address wrap: index DEPTH aliases to 0, e.g. DEPTH=1024 with address 0x0000_1000 hits word 0.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: misalignment is a halfword with address[0]=1, or a word store/load with address[1:0] != 00.
  - align_err pulses high the cycle after the offending request.
  - A misaligned store is suppressed and the array is unchanged.
  - A misaligned load proceeds with address[1:0] treated as 00.
- Not defined:
  - align_err is tied 0 and no access is suppressed.
  - Word accesses ignore address[1:0].
  - Halfword accesses ignore address[0].

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10 followed by a load of 0x10 with READ_LAT=2 -> mem_stall high 3 cycles; in RESP, resp_valid=1 and read_data=0xDEADBEEF.
- Word store 0x11223344 to 0x20, byte store 0xAA to 0x21, half store 0x5566 to 0x22, then load 0x20 -> read_data=0x5566AA44.
- Load issued, rst_n low during the second BUSY cycle -> next cycle state IDLE, mem_stall 0, read_data 0, resp_valid never asserts.
- MemRead=1 with MemWrite=11 (data 0x0000_00FF) at 0x30 -> no stall, word 0x30 = 0x000000FF, no resp_valid.
- DEPTH=1024: store 0xCAFEF00D to 0x0000_1004, then load 0x4 -> read_data=0xCAFEF00D.
- With DMEM_ALIGN_CHECK_EN: word store 0x12345678 to 0x42 -> align_err pulses 1 cycle, word 0x40 unchanged. Without the macro: the same store writes word 0x40 = 0x12345678 and align_err stays 0.
